sbmips_controller: RTL and testbench

Multicycle control FSM for the stack-based MIPS datapath (8-bit data, 5-bit address, 8-bit instruction). It decodes the instruction register output `Inst` and drives every datapath control input, one state per cycle, to sequence fetch, stack arithmetic, memory push/pop and jumps. It sits beside the datapath in the top-level CPU. Its only inputs are `Inst` and the clock/reset; branch conditioning is done inside the datapath through `PCwriteCond`.

---
 rtl/sbmips_controller.sv | 145 ++++++++++++++
 tb/tb_sbmips_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sbmips_controller.sv
// Multicycle control FSM for the stack-based MIPS datapath.
// Sequences fetch, stack ALU ops, memory push/pop and jumps, one state per cycle.
module sbmips_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Inst,
  output logic       PCsrc,
  output logic       PCwrite,
  output logic       PCwriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Ild,
  output logic       Ssrc,
  output logic       Push,
  output logic       Pop,
  output logic       Tos,
  output logic       Bld,
  output logic       ALUsrc1,
  output logic [1:0] ALUsrc2,
  output logic [1:0] ALUop
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_POP1, S_POP2, S_WB, S_MEMRD, S_MEMWR, S_BR
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_JZ   = 3'd7;

  state_t     state;
  logic [2:0] op_q;
  logic [2:0] op;

  // Target field is consumed by the datapath only.
  logic unused_tgt;
  assign unused_tgt = ^Inst[4:0];

  // Inst is loaded on the edge entering ID, so ID decodes it directly.
  assign op = (state == S_ID) ? Inst[7:5] : op_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IF;
      op_q  <= OP_ADD;
    end else begin
      if (state == S_ID) op_q <= Inst[7:5];
      case (state)
        S_IF:   state <= S_ID;
        S_ID:
          case (Inst[7:5])
            OP_PUSH: state <= S_MEMRD;
            OP_JMP:  state <= S_IF;
            default: state <= S_POP1;
          endcase
        S_POP1:
          case (op_q)
            OP_ADD, OP_SUB, OP_AND: state <= S_POP2;
            OP_NOT:  state <= S_WB;
            OP_POP:  state <= S_MEMWR;
            OP_JZ:   state <= S_BR;
            default: state <= S_IF;
          endcase
        S_POP2:  state <= S_WB;
        default: state <= S_IF;
      endcase
    end
  end

  // Moore decode; everything held low while reset is asserted.
  always_comb begin
    PCsrc       = 1'b0;
    PCwrite     = 1'b0;
    PCwriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Ild         = 1'b0;
    Ssrc        = 1'b0;
    Push        = 1'b0;
    Pop         = 1'b0;
    Tos         = 1'b0;
    Bld         = 1'b0;
    ALUsrc1     = 1'b0;
    ALUsrc2     = 2'b00;
    ALUop       = 2'b00;
    if (rst) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          Ild     = 1'b1;
          ALUsrc2 = 2'b10;
          PCwrite = 1'b1;
        end
        S_ID:
          if (op == OP_JMP) begin
            PCsrc   = 1'b1;
            PCwrite = 1'b1;
          end
        S_POP1: Pop = 1'b1;
        S_POP2: begin
          Pop = 1'b1;
          Bld = 1'b1;
        end
        S_WB: begin
          Push    = 1'b1;
          ALUsrc1 = 1'b1;
          case (op)
            OP_SUB: ALUop = 2'b01;
            OP_AND: ALUop = 2'b10;
            OP_NOT: begin
              ALUsrc2 = 2'b01;
              ALUop   = 2'b11;
            end
            default: ;
          endcase
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          Ssrc    = 1'b1;
          Push    = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_BR: begin
          ALUsrc1     = 1'b1;
          ALUsrc2     = 2'b01;
          PCsrc       = 1'b1;
          PCwriteCond = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbmips_controller.sv
// Controller driving a behavioural stack datapath; per-instruction results scoreboarded.
module tb_sbmips_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] Inst;
  logic       PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild;
  logic       Ssrc, Push, Pop, Tos, Bld, ALUsrc1;
  logic [1:0] ALUsrc2, ALUop;

  always #5 clk = ~clk;

  sbmips_controller dut (
    .clk(clk), .rst(rst), .Inst(Inst),
    .PCsrc(PCsrc), .PCwrite(PCwrite), .PCwriteCond(PCwriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .Ild(Ild), .Ssrc(Ssrc),
    .Push(Push), .Pop(Pop), .Tos(Tos), .Bld(Bld), .ALUsrc1(ALUsrc1),
    .ALUsrc2(ALUsrc2), .ALUop(ALUop)
  );

  // Behavioural datapath
  logic [7:0] prog [32];
  logic [7:0] mem  [32];
  logic [7:0] stk  [16];
  logic [3:0] sp;
  logic [4:0] pc;
  logic [7:0] ir, sdo, breg;
  logic [4:0] maddr;
  logic [7:0] rdata, a_in, b_in, alu, wdata;

  assign Inst  = ir;
  assign maddr = IorD ? ir[4:0] : pc;
  assign rdata = mem[maddr];
  assign a_in  = ALUsrc1 ? sdo : {3'b000, pc};
  always_comb begin
    case (ALUsrc2)
      2'b00:   b_in = breg;
      2'b01:   b_in = 8'd0;
      2'b10:   b_in = 8'd1;
      default: b_in = sdo;
    endcase
    case (ALUop)
      2'b00:   alu = a_in + b_in;
      2'b01:   alu = a_in - b_in;
      2'b10:   alu = a_in & b_in;
      default: alu = ~a_in;
    endcase
  end
  assign wdata = Ssrc ? rdata : alu;

  always @(posedge clk) begin
    if (!rst) begin
      pc <= 5'd0; sp <= 4'd0; ir <= 8'd0; sdo <= 8'd0; breg <= 8'd0;
      mem <= prog;
    end else begin
      if (PCwrite || (PCwriteCond && alu == 8'd0)) pc <= PCsrc ? ir[4:0] : alu[4:0];
      if (Ild) ir <= rdata;
      if (MemWrite) mem[maddr] <= sdo;
      if (Bld) breg <= sdo;
      if (Push) begin
        stk[sp] <= wdata;
        sp <= sp + 4'd1;
      end else if (Pop) begin
        sdo <= stk[sp - 4'd1];
        sp <= sp - 4'd1;
      end else if (Tos) sdo <= stk[sp - 4'd1];
    end
  end

  logic [16:0] ovec;
  assign ovec = {PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild, Ssrc,
                 Push, Pop, Tos, Bld, ALUsrc1, ALUsrc2, ALUop};
  localparam logic [16:0] IF_VEC = 17'b0_1_0_0_1_0_1_0_0_0_0_0_0_10_00;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] top;
    bit         ck_top;
    logic [4:0] pc;
    bit         ck_pc;
    bit         ck_mem6;
  } exp_t;
  exp_t sb[$];

  string opn [8] = '{"add", "sub", "and", "not", "push", "pop", "jmp", "jz"};

  task automatic put(input logic [4:0] addr, input logic [7:0] inst,
                     input bit ck_top, input logic [7:0] top,
                     input bit ck_pc, input logic [4:0] npc, input bit ck_mem6);
    exp_t e;
    prog[addr] = inst;
    e.op = inst[7:5]; e.top = top; e.ck_top = ck_top;
    e.pc = npc; e.ck_pc = ck_pc; e.ck_mem6 = ck_mem6;
    sb.push_back(e);
  endtask

  int  cyc, n_pop, n_push, n_pb, n_iord, n_iord_bad, n_mw, n_pwc;
  logic [3:0] wb_sel;
  bit  busy, done;

  task automatic step();
    exp_t e;
    int ecyc, epop, epush, epb, eiord, emw, epwc;
    logic [3:0] esel;
    chk("excl", 32'({Push & Pop, MemRead & MemWrite}), 32'd0);
    if (Ild) begin
      if (busy && sb.size() > 0) begin
        e = sb.pop_front();
        chk({opn[e.op], "_ir_op"}, 32'(ir[7:5]), 32'(e.op));
        epop = 0; epush = 0; epb = 0; eiord = 0; emw = 0; epwc = 0; esel = 4'h0;
        case (e.op)
          3'd0, 3'd1, 3'd2: begin ecyc = 5; epop = 2; epush = 1; epb = 1;
                                  esel = {2'b00, 2'(e.op)}; end
          3'd3: begin ecyc = 4; epop = 1; epush = 1; esel = 4'b0111; end
          3'd4: begin ecyc = 3; epush = 1; eiord = 1; end
          3'd5: begin ecyc = 4; epop = 1; eiord = 1; emw = 1; end
          3'd6: ecyc = 2;
          default: begin ecyc = 4; epop = 1; epwc = 1; end
        endcase
        chk({opn[e.op], "_cycles"}, 32'(cyc), 32'(ecyc));
        chk({opn[e.op], "_pop"}, 32'(n_pop), 32'(epop));
        chk({opn[e.op], "_push"}, 32'(n_push), 32'(epush));
        chk({opn[e.op], "_popbld"}, 32'(n_pb), 32'(epb));
        chk({opn[e.op], "_iord"}, 32'(n_iord), 32'(eiord));
        chk({opn[e.op], "_iord_bad"}, 32'(n_iord_bad), 32'd0);
        chk({opn[e.op], "_memwr"}, 32'(n_mw), 32'(emw));
        chk({opn[e.op], "_pwcond"}, 32'(n_pwc), 32'(epwc));
        if (e.op <= 3'd3) chk({opn[e.op], "_wb_alu"}, 32'(wb_sel), 32'(esel));
        if (e.ck_top) chk({opn[e.op], "_top"}, 32'(stk[sp - 4'd1]), 32'(e.top));
        if (e.ck_pc) chk({opn[e.op], "_pc"}, 32'(pc), 32'(e.pc));
        if (e.ck_mem6) chk("mem6", 32'(mem[6]), 32'h3C);
        if (sb.size() == 0) done = 1;
      end
      busy = 1;
      cyc = 0; n_pop = 0; n_push = 0; n_pb = 0; n_iord = 0; n_iord_bad = 0;
      n_mw = 0; n_pwc = 0; wb_sel = 4'hF;
    end
    cyc++;
    n_pop += int'(Pop);
    n_push += int'(Push);
    n_pb += int'(Pop & Bld);
    n_iord += int'(IorD);
    n_iord_bad += int'(IorD & ~(MemWrite | (Push & Ssrc)));
    n_mw += int'(MemWrite);
    n_pwc += int'(PCwriteCond);
    if (Push && !Ssrc) wb_sel = {ALUsrc2, ALUop};
  endtask

  initial begin
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    busy = 0; done = 0;

    // Reset mid-ADD at POP2
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst_rel_if", 32'(ovec), 32'(IF_VEC));
    repeat (3) @(negedge clk);
    chk("add_pop2_popbld", 32'({Pop, Bld}), 32'b11);
    rst = 1'b0;
    #1 chk("rst_outs0", 32'(ovec), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold0", 32'(ovec), 32'd0);
    end
    rst = 1'b1;
    #1 chk("rst_after_if", 32'(ovec), 32'(IF_VEC));
    chk("rst_after_pcw_ild", 32'({PCwrite, Ild}), 32'b11);

    // Main program, scoreboard entries in execution order
    @(negedge clk); rst = 1'b0;
    prog[5] = 8'h3C; prog[7] = 8'h07; prog[8] = 8'h02; prog[15] = 8'h01;
    prog[16] = 8'hF0; prog[17] = 8'h3C; prog[18] = 8'h00; prog[19] = 8'h01;
    put(5'd0,  8'h85, 1, 8'h3C, 0, 5'd0, 0);  // PUSH 5
    put(5'd1,  8'hA6, 0, 8'h00, 1, 5'd2, 1);  // POP 6
    put(5'd2,  8'hD4, 0, 8'h00, 1, 5'd20, 0); // JMP 20
    put(5'd20, 8'h87, 1, 8'h07, 0, 5'd0, 0);  // PUSH 7
    put(5'd21, 8'h88, 1, 8'h02, 0, 5'd0, 0);  // PUSH 8
    put(5'd22, 8'h20, 1, 8'h05, 0, 5'd0, 0);  // SUB
    put(5'd23, 8'h8F, 1, 8'h01, 0, 5'd0, 0);  // PUSH 15
    put(5'd24, 8'h00, 1, 8'h06, 0, 5'd0, 0);  // ADD
    put(5'd25, 8'h90, 1, 8'hF0, 0, 5'd0, 0);  // PUSH 16
    put(5'd26, 8'h91, 1, 8'h3C, 0, 5'd0, 0);  // PUSH 17
    put(5'd27, 8'h40, 1, 8'h30, 0, 5'd0, 0);  // AND
    put(5'd28, 8'h60, 1, 8'hCF, 0, 5'd0, 0);  // NOT
    put(5'd29, 8'h92, 1, 8'h00, 0, 5'd0, 0);  // PUSH 18
    put(5'd30, 8'hE9, 1, 8'hCF, 1, 5'd9, 0);  // JZ 9, taken
    put(5'd9,  8'h93, 1, 8'h01, 0, 5'd0, 0);  // PUSH 19
    put(5'd10, 8'hE9, 1, 8'hCF, 1, 5'd11, 0); // JZ 9, not taken
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1 step();
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
